// File: rtl/m_sync_detect.sv
// Symbol-timing recovery for the M-sequence correlator: finds a correlation peak,
// locks to the SEQ_LEN-clock period and slices one bit per expected peak slot.
module m_sync_detect #(
  parameter int unsigned SEQ_LEN      = 31,
  parameter logic [7:0]  THR_HI       = 8'd56,
  parameter logic [7:0]  THR_LO       = 8'd6,
  parameter int unsigned MISS_MAX     = 3,
  // value bit_cnt takes on reset; nonzero only to bring the wrap into short runs
  parameter logic [15:0] BIT_CNT_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  corr,
  output logic        bit_out,
  output logic        bit_valid,
  output logic        miss,
  output logic        locked,
  output logic [7:0]  peak_val,
  output logic [15:0] bit_cnt
);
  localparam int PH_W = $clog2(SEQ_LEN);
  localparam logic SEARCH = 1'b0;
  localparam logic LOCK   = 1'b1;

  logic            state;
  logic [PH_W-1:0] phase;
  logic [3:0]      miss_cnt;
  logic            peak_hi, peak_lo, peak, slot;

  assign peak_hi = (corr >= THR_HI);
  assign peak_lo = (corr <= THR_LO);
  assign peak    = peak_hi | peak_lo;
  // slot lands exactly SEQ_LEN clocks after the previous accepted sample
  assign slot    = (phase == PH_W'(SEQ_LEN - 1));
  assign locked  = (state == LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      phase     <= '0;
      miss_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      miss      <= 1'b0;
      peak_val  <= '0;
      bit_cnt   <= BIT_CNT_INIT;
    end else begin
      bit_valid <= 1'b0;
      miss      <= 1'b0;
      if (state == SEARCH) begin
        if (peak) begin
          bit_valid <= 1'b1;
          bit_out   <= peak_hi;
          peak_val  <= corr;
          bit_cnt   <= bit_cnt + 16'd1;
          phase     <= '0;
          miss_cnt  <= '0;
          state     <= LOCK;
        end
      end else if (slot) begin
        phase <= '0;
        if (peak) begin
          bit_valid <= 1'b1;
          bit_out   <= peak_hi;
          peak_val  <= corr;
          bit_cnt   <= bit_cnt + 16'd1;
          miss_cnt  <= '0;
        end else begin
          miss <= 1'b1;
          if (miss_cnt + 4'd1 == 4'(MISS_MAX)) begin
            state    <= SEARCH;
            miss_cnt <= '0;
          end else begin
            miss_cnt <= miss_cnt + 4'd1;
          end
        end
      end else begin
        // off-slot peaks are deliberately ignored: no re-alignment while locked
        phase <= phase + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_m_sync_detect.sv
// Directed bench for m_sync_detect: timeline table of vectors plus a bit_cnt wrap
// sequence on a second instance whose counter resets near 0xFFFF.
module tb_m_sync_detect;
  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [7:0]  corr, corr2;
  logic        bit_out, bit_valid, miss, locked;
  logic [7:0]  peak_val;
  logic [15:0] bit_cnt;
  logic        bit_out2, bit_valid2, miss2, locked2;
  logic [7:0]  peak_val2;
  logic [15:0] bit_cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_sync_detect dut (
    .clk(clk), .rst(rst), .corr(corr),
    .bit_out(bit_out), .bit_valid(bit_valid), .miss(miss), .locked(locked),
    .peak_val(peak_val), .bit_cnt(bit_cnt)
  );

  m_sync_detect #(.BIT_CNT_INIT(16'hFFFE)) dut_wrap (
    .clk(clk), .rst(rst2), .corr(corr2),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .miss(miss2), .locked(locked2),
    .peak_val(peak_val2), .bit_cnt(bit_cnt2)
  );

  typedef struct {
    int          cyc;
    logic        rst;
    logic [7:0]  corr;
    logic        bv, bo, ms, lk;
    logic [7:0]  pv;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec[$];

  task automatic add(input int cyc, input logic r, input logic [7:0] c,
                     input logic bv, input logic bo, input logic ms, input logic lk,
                     input logic [7:0] pv, input logic [15:0] cnt);
    vec_t v;
    v.cyc = cyc; v.rst = r; v.corr = c;
    v.bv = bv; v.bo = bo; v.ms = ms; v.lk = lk; v.pv = pv; v.cnt = cnt;
    vec.push_back(v);
  endtask

  task automatic chk(input string nm, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step2(input logic r, input logic [7:0] c);
    rst2 = r; corr2 = c;
    @(posedge clk); #1;
  endtask

  initial begin
    int idx;
    bit has;
    rst = 1'b1; corr = 8'd31; rst2 = 1'b1; corr2 = 8'd31;

    //   cyc  rst corr  bv bo ms lk  pv  cnt   (outputs seen one clk after the sample)
    add(  0, 1, 31,   0, 0, 0, 0,  0, 0);
    add(  1, 1, 31,   0, 0, 0, 0,  0, 0);
    add( 10, 0, 62,   1, 1, 0, 1, 62, 1);
    add( 40, 0, 31,   0, 0, 0, 1, 62, 1);
    add( 41, 0, 62,   1, 1, 0, 1, 62, 2);
    add( 72, 0,  0,   1, 0, 0, 1,  0, 3);
    add(103, 0, 56,   1, 1, 0, 1, 56, 4);
    add(134, 0, 55,   0, 0, 1, 1, 56, 4);
    add(165, 0,  6,   1, 0, 0, 1,  6, 5);
    add(196, 0, 62,   1, 1, 0, 1, 62, 6);
    add(227, 0, 31,   0, 0, 1, 1, 62, 6);
    add(232, 0, 62,   0, 0, 0, 1, 62, 6);
    add(258, 0, 31,   0, 0, 1, 1, 62, 6);
    add(288, 0, 31,   0, 0, 0, 1, 62, 6);
    add(289, 0, 31,   0, 0, 1, 0, 62, 6);
    add(295, 0, 55,   0, 0, 0, 0, 62, 6);
    add(296, 0,  7,   0, 0, 0, 0, 62, 6);
    add(300, 0, 62,   1, 1, 0, 1, 62, 7);
    add(331, 0, 31,   0, 0, 1, 1, 62, 7);
    add(362, 0, 31,   0, 0, 1, 1, 62, 7);
    add(393, 0,  0,   1, 0, 0, 1,  0, 8);
    add(424, 0, 31,   0, 0, 1, 1,  0, 8);
    add(455, 0, 31,   0, 0, 1, 1,  0, 8);
    add(486, 0, 60,   1, 1, 0, 1, 60, 9);
    add(502, 1, 31,   0, 0, 0, 0,  0, 0);
    add(517, 0, 31,   0, 0, 0, 0,  0, 0);

    idx = 0;
    for (int c = 0; c < 530; c++) begin
      has = (idx < vec.size()) && (vec[idx].cyc == c);
      rst = 1'b0; corr = 8'd31;
      if (has) begin
        rst = vec[idx].rst; corr = vec[idx].corr;
      end
      @(posedge clk); #1;
      if (has) begin
        chk("bit_valid", c, 32'(bit_valid), 32'(vec[idx].bv));
        if (vec[idx].bv) chk("bit_out", c, 32'(bit_out), 32'(vec[idx].bo));
        chk("miss", c, 32'(miss), 32'(vec[idx].ms));
        chk("locked", c, 32'(locked), 32'(vec[idx].lk));
        chk("peak_val", c, 32'(peak_val), 32'(vec[idx].pv));
        chk("bit_cnt", c, 32'(bit_cnt), 32'(vec[idx].cnt));
        idx++;
      end else begin
        chk("idle_pulses", c, {30'd0, bit_valid, miss}, 32'd0);
      end
    end

    // bit_cnt wrap: reset value 0xFFFE, three decoded bits walk through 0xFFFF -> 0 -> 1
    step2(1'b1, 8'd31);
    step2(1'b1, 8'd31);
    chk("wrap_reset_cnt", 0, 32'(bit_cnt2), 32'h0000FFFE);
    step2(1'b0, 8'd62);
    chk("wrap_cnt_ffff", 1, 32'(bit_cnt2), 32'h0000FFFF);
    chk("wrap_bv1", 1, 32'(bit_valid2), 32'd1);
    for (int k = 0; k < 30; k++) step2(1'b0, 8'd31);
    step2(1'b0, 8'd3);
    chk("wrap_cnt_0", 2, 32'(bit_cnt2), 32'd0);
    chk("wrap_bv2", 2, 32'(bit_valid2), 32'd1);
    chk("wrap_bo2", 2, 32'(bit_out2), 32'd0);
    for (int k = 0; k < 30; k++) step2(1'b0, 8'd31);
    step2(1'b0, 8'd200);
    chk("wrap_cnt_1", 3, 32'(bit_cnt2), 32'd1);
    chk("wrap_pv", 3, 32'(peak_val2), 32'd200);
    chk("wrap_locked", 3, 32'(locked2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
